// File: rtl/alu_sched_pkg.sv
// Shared types for the ALU issue scheduler.
//  sched_entry_t : one queued op (op_func, operands, ROB tag)
//  is_mem()      : true for LOAD/STORE opcodes (they need the LSQ address port)
package alu_sched_pkg;
  localparam int OPRAND_W  = 32;
  localparam int OP_FUNC_W = 17;
  localparam int TAG_W     = 4;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  typedef struct packed {
    logic [OP_FUNC_W-1:0] op_func;
    logic [OPRAND_W-1:0]  opa;
    logic [OPRAND_W-1:0]  opb;
    logic [TAG_W-1:0]     tag;
  } sched_entry_t;

  // Only the opcode field decides memory-ness.
  function automatic logic is_mem(input logic [6:0] opcode);
    return (opcode == OPC_LOAD) || (opcode == OPC_STORE);
  endfunction
endpackage

// File: rtl/alu_issue_queue.sv
// Circular op buffer for the issue scheduler.
//  push/push_data : enqueue one entry at tail
//  pop_cnt        : retire 0..2 entries from head
//  e0/e1          : entries at head and head+1 (validity implied by count)
//  count/full     : occupancy; full when indices match and wrap bits differ
//  flush          : empties the queue at the next edge
module alu_issue_queue
  import alu_sched_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  sched_entry_t push_data,
  input  logic [1:0]   pop_cnt,
  output sched_entry_t e0,
  output sched_entry_t e1,
  output logic [AW:0]  count,
  output logic         full
);
  sched_entry_t mem [DEPTH];
  logic [AW:0]   head, tail;
  logic [AW-1:0] head1;

  assign head1 = head[AW-1:0] + AW'(1);
  assign e0    = mem[head[AW-1:0]];
  assign e1    = mem[head1];
  // Wrap bit makes the subtraction exact across the full/empty ambiguity.
  assign count = tail - head;
  assign full  = (head[AW] != tail[AW]) && (head[AW-1:0] == tail[AW-1:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
    end else if (flush) begin
      head <= '0;
      tail <= '0;
    end else begin
      if (push) tail <= tail + (AW+1)'(1);
      head <= head + (AW+1)'(pop_cnt);
    end
  end

  // Storage needs no reset: contents are only meaningful below count.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[tail[AW-1:0]] <= push_data;
  end
endmodule

// File: rtl/alu_issue_sched.sv
// In-order dual-lane ALU issue scheduler.
//  disp_*    : ROB dispatch handshake into the op queue
//  lsq_ready : LSQ can take an address this cycle (gates mem ops)
//  op_funcN/operandNx : registered lane slots driven to the ALU lanes
//  resultN   : combinational ALU results, passed through to writeback
//  wbN_*     : tagged writeback to the ROB
//  count_o   : queue occupancy
module alu_issue_sched
  import alu_sched_pkg::*;
#(
  // Widths are tied to the package entry type; keep them at the defaults.
  parameter int OPRAND_WIDTH  = OPRAND_W,
  parameter int OP_FUNC_WIDTH = OP_FUNC_W,
  parameter int DEPTH         = 8,
  parameter int TAG_WIDTH     = TAG_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush_i,
  input  logic                     disp_valid_i,
  output logic                     disp_ready_o,
  input  logic [OP_FUNC_WIDTH-1:0] disp_op_func_i,
  input  logic [OPRAND_WIDTH-1:0]  disp_opa_i,
  input  logic [OPRAND_WIDTH-1:0]  disp_opb_i,
  input  logic [TAG_WIDTH-1:0]     disp_tag_i,
  input  logic                     lsq_ready_i,
  output logic [OP_FUNC_WIDTH-1:0] op_func1_o,
  output logic [OPRAND_WIDTH-1:0]  operand11_o,
  output logic [OPRAND_WIDTH-1:0]  operand12_o,
  output logic [OP_FUNC_WIDTH-1:0] op_func2_o,
  output logic [OPRAND_WIDTH-1:0]  operand21_o,
  output logic [OPRAND_WIDTH-1:0]  operand22_o,
  input  logic [OPRAND_WIDTH-1:0]  result1_i,
  input  logic [OPRAND_WIDTH-1:0]  result2_i,
  output logic                     wb1_valid_o,
  output logic [TAG_WIDTH-1:0]     wb1_tag_o,
  output logic [OPRAND_WIDTH-1:0]  wb1_result_o,
  output logic                     wb2_valid_o,
  output logic [TAG_WIDTH-1:0]     wb2_tag_o,
  output logic [OPRAND_WIDTH-1:0]  wb2_result_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int NUM_LANES = 2;
  localparam int CW        = $clog2(DEPTH) + 1;

  sched_entry_t                 e0, e1, din;
  sched_entry_t [NUM_LANES-1:0] ent, lane_q;
  logic [NUM_LANES-1:0]         iss, lane_vld;
  logic [1:0]                   pop_cnt;
  logic [CW-1:0]                count;
  logic                         full, push, mem0, mem1;

  assign disp_ready_o = !full;
  assign push = disp_valid_i && !full && !flush_i;
  assign din  = '{op_func: disp_op_func_i, opa: disp_opa_i, opb: disp_opb_i, tag: disp_tag_i};

  alu_issue_queue #(.DEPTH(DEPTH)) u_q (
    .clk(clk), .rst_n(rst_n), .flush(flush_i), .push(push), .push_data(din),
    .pop_cnt(pop_cnt), .e0(e0), .e1(e1), .count(count), .full(full)
  );

  // count is registered, so an op enqueued this cycle is invisible to issue
  // until the next one.
  assign mem0   = is_mem(e0.op_func[6:0]);
  assign mem1   = is_mem(e1.op_func[6:0]);
  assign iss[0] = (count != '0) && (!mem0 || lsq_ready_i);
  // Only one LSQ address per cycle: two mem ops never pair.
  assign iss[1] = iss[0] && (count > CW'(1)) && !(mem0 && mem1) && (!mem1 || lsq_ready_i);
  assign pop_cnt = flush_i ? 2'd0 : ({1'b0, iss[0]} + {1'b0, iss[1]});
  assign ent     = {e1, e0};

  generate
    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          lane_vld[l] <= 1'b0;
          lane_q[l]   <= '0;
        end else if (iss[l] && !flush_i) begin
          lane_vld[l] <= 1'b1;
          lane_q[l]   <= ent[l];
        end else begin
          // Idle lane shows NOP so the LSQ address mux ignores it;
          // operands and tag hold.
          lane_vld[l]         <= 1'b0;
          lane_q[l].op_func   <= '0;
        end
      end
    end
  endgenerate

  assign op_func1_o   = lane_q[0].op_func;
  assign operand11_o  = lane_q[0].opa;
  assign operand12_o  = lane_q[0].opb;
  assign op_func2_o   = lane_q[1].op_func;
  assign operand21_o  = lane_q[1].opa;
  assign operand22_o  = lane_q[1].opb;
  assign wb1_valid_o  = lane_vld[0];
  assign wb1_tag_o    = lane_q[0].tag;
  assign wb1_result_o = result1_i;
  assign wb2_valid_o  = lane_vld[1];
  assign wb2_tag_o    = lane_q[1].tag;
  assign wb2_result_o = result2_i;
  assign count_o      = count;
endmodule

// File: tb/tb_alu_issue_sched.sv
// Randomized + directed bench for alu_issue_sched with a queue-based
// reference model and a per-edge scoreboard checked by a separate monitor.
module tb_alu_issue_sched;
  localparam int DEPTH = 8;
  localparam logic [16:0] ADD = 17'h00033, SUB = 17'h000B3,
                          LOAD = 17'h00003, STORE = 17'h00023;

  logic        clk = 0, rst_n = 0, flush = 0, dv = 0, lsq = 0;
  logic [16:0] dop = '0;
  logic [31:0] da = '0, db = '0;
  logic [3:0]  dtag = '0;
  logic        drdy, wb1v, wb2v;
  logic [16:0] op1, op2;
  logic [31:0] o11, o12, o21, o22, res1, res2, wb1r, wb2r;
  logic [3:0]  wb1t, wb2t, cnt;

  always #5 clk = ~clk;

  // Bench-side ALU: bit 7 selects subtract, everything else adds.
  function automatic logic [31:0] alu(logic [16:0] op, logic [31:0] a, logic [31:0] b);
    return op[7] ? a - b : a + b;
  endfunction
  function automatic bit mem_op(logic [16:0] op);
    return op[6:0] == 7'h03 || op[6:0] == 7'h23;
  endfunction

  assign res1 = alu(op1, o11, o12);
  assign res2 = alu(op2, o21, o22);

  alu_issue_sched dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush), .disp_valid_i(dv), .disp_ready_o(drdy),
    .disp_op_func_i(dop), .disp_opa_i(da), .disp_opb_i(db), .disp_tag_i(dtag),
    .lsq_ready_i(lsq), .op_func1_o(op1), .operand11_o(o11), .operand12_o(o12),
    .op_func2_o(op2), .operand21_o(o21), .operand22_o(o22),
    .result1_i(res1), .result2_i(res2),
    .wb1_valid_o(wb1v), .wb1_tag_o(wb1t), .wb1_result_o(wb1r),
    .wb2_valid_o(wb2v), .wb2_tag_o(wb2t), .wb2_result_o(wb2r), .count_o(cnt)
  );

  typedef struct {logic [16:0] op; logic [31:0] a; logic [31:0] b; logic [3:0] tag;} ent_t;
  typedef struct {bit v1; bit v2; ent_t e1; ent_t e2; int cnt;} rec_t;

  ent_t mq[$];   // reference queue contents
  rec_t sb[$];   // expected DUT state after each edge
  int errors = 0, checks = 0;
  logic [3:0] ntag = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic ent_t mk(logic [16:0] op, logic [31:0] a, logic [31:0] b);
    ent_t e;
    e.op = op; e.a = a; e.b = b; e.tag = ntag;
    ntag = ntag + 1;
    return e;
  endfunction

  // Drive one cycle of inputs and predict the state after the coming edge.
  task automatic cyc(bit v, ent_t d, bit l, bit f);
    rec_t r;
    int n;
    @(negedge clk);
    dv = v; dop = d.op; da = d.a; db = d.b; dtag = d.tag; lsq = l; flush = f;
    n = mq.size();
    r.v1 = 0; r.v2 = 0; r.e1 = d; r.e2 = d;
    if (f) mq.delete();
    else begin
      if (n >= 1 && (!mem_op(mq[0].op) || l)) begin r.v1 = 1; r.e1 = mq[0]; end
      if (r.v1 && n >= 2 && !(mem_op(mq[0].op) && mem_op(mq[1].op)) &&
          (!mem_op(mq[1].op) || l)) begin r.v2 = 1; r.e2 = mq[1]; end
      if (r.v1) void'(mq.pop_front());
      if (r.v2) void'(mq.pop_front());
      if (v && n < DEPTH) mq.push_back(d);
    end
    r.cnt = mq.size();
    sb.push_back(r);
  endtask

  task automatic idle(int k, bit l);
    ent_t z;
    z.op = '0; z.a = '0; z.b = '0; z.tag = '0;
    for (int i = 0; i < k; i++) cyc(0, z, l, 0);
  endtask

  // Monitor: compare DUT against the record of the edge just taken.
  initial begin
    rec_t r;
    forever begin
      @(posedge clk); #1;
      if (sb.size() > 0) begin
        r = sb.pop_front();
        chk("wb1_valid", wb1v, r.v1);
        chk("wb2_valid", wb2v, r.v2);
        chk("op_func1", op1, r.v1 ? r.e1.op : 17'h0);
        chk("op_func2", op2, r.v2 ? r.e2.op : 17'h0);
        if (r.v1) begin
          chk("wb1_tag", wb1t, r.e1.tag);
          chk("wb1_result", wb1r, alu(r.e1.op, r.e1.a, r.e1.b));
        end
        if (r.v2) begin
          chk("wb2_tag", wb2t, r.e2.tag);
          chk("wb2_result", wb2r, alu(r.e2.op, r.e2.a, r.e2.b));
        end
        chk("count", cnt, r.cnt);
        chk("disp_ready", drdy, r.cnt < DEPTH);
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", cnt, 0);
    chk("rst_wb_valid", {wb1v, wb2v}, 0);
    chk("rst_op_func", {op1, op2}, 0);
    @(negedge clk) rst_n = 1;
    #1 chk("rst_ready", drdy, 1);

    // 1: three ADDs
    ntag = 1;
    for (int i = 0; i < 3; i++) cyc(1, mk(ADD, 32'(i * 10), 32'd3), 1, 0);
    idle(3, 1);
    // 2: head LOAD blocked, fill past full, then release
    cyc(1, mk(LOAD, 32'h100, 32'h4), 0, 0);
    for (int i = 0; i < 9; i++) cyc(1, mk(ADD, 32'(i), 32'd1), 0, 0);
    idle(1, 0);
    idle(8, 1);
    // 3: LOAD then STORE, both resident before LSQ opens
    cyc(1, mk(LOAD, 32'h200, 32'h8), 0, 0);
    cyc(1, mk(STORE, 32'h300, 32'hC), 0, 0);
    idle(1, 0);
    idle(3, 1);
    // 4: SUB 5-7 then STORE with LSQ closed
    cyc(1, mk(SUB, 32'd5, 32'd7), 0, 0);
    cyc(1, mk(STORE, 32'h40, 32'h0), 0, 0);
    idle(3, 0);
    idle(3, 1);
    // 5: six ops held behind a LOAD, then flush with a dispatch
    cyc(1, mk(LOAD, 32'h10, 32'h0), 0, 0);
    for (int i = 0; i < 5; i++) cyc(1, mk(ADD, 32'(i), 32'd2), 0, 0);
    cyc(1, mk(ADD, 32'd99, 32'd1), 0, 1);
    idle(3, 1);
    // 6: 20 ADDs at full rate across pointer wrap
    for (int i = 0; i < 20; i++) cyc(1, mk(ADD, $urandom, $urandom), 1, 0);
    idle(4, 1);
    // random mix
    for (int i = 0; i < 400; i++) begin
      logic [16:0] op;
      case ($urandom % 4)
        0: op = ADD | {9'($urandom), 8'h00};
        1: op = SUB;
        2: op = LOAD;
        default: op = STORE;
      endcase
      cyc(($urandom % 4) != 0, mk(op, $urandom, $urandom), ($urandom % 3) != 0,
          ($urandom % 40) == 0);
    end
    idle(10, 1);
    // async reset while lanes are busy
    for (int i = 0; i < 3; i++) cyc(1, mk(ADD, 32'(i), 32'd1), 1, 0);
    @(posedge clk); #2;
    rst_n = 0;
    #1;
    chk("arst_wb_valid", {wb1v, wb2v}, 0);
    chk("arst_count", cnt, 0);
    chk("arst_op_func", {op1, op2}, 0);
    mq.delete();
    chk("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
